// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, FSM states and datapath select encodings
// Purpose: constants and types shared by the multi-cycle control FSM and its
// decode table. No ports.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BTYPE    = 7'b1100011;
    localparam logic [6:0] OP_LOADS    = 7'b0000011;
    localparam logic [6:0] OP_STORES   = 7'b0100011;
    localparam logic [6:0] OP_ARITHM_I = 7'b0010011;
    localparam logic [6:0] OP_ARITHM_R = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_ALU   = 2'd1;
    localparam logic [1:0] PC_SEL_BR    = 2'd2;

    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_PC   = 2'd1;
    localparam logic [1:0] A_SEL_ZERO = 2'd2;

    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // Instruction class decides the path after EXEC.
    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_JUMP,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE
    } cls_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] a_sel;
        logic       b_sel;
        logic [1:0] wb_sel;
        logic [1:0] pc_sel;
        cls_t       cls;
    } dec_t;

endpackage

// File: rtl/rv_ctrl_decode_table.sv
// rtl/rv_ctrl_decode_table.sv - opcode/funct3 to control-class lookup
// Purpose: combinational decode of an RV32I opcode/funct3 pair into legality,
// ALU operand selects, writeback select, writeback PC select and class.
// Ports:
//   op     in  7  opcode
//   funct3 in  3  funct3 field
//   dec    out    decoded control bundle (dec_t)
module rv_ctrl_decode_table
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    output dec_t       dec
);

    always_comb begin
        dec.legal  = 1'b0;
        dec.a_sel  = A_SEL_RS1;
        dec.b_sel  = B_SEL_IMM;
        dec.wb_sel = WB_SEL_ALU;
        dec.pc_sel = PC_SEL_PLUS4;
        dec.cls    = CLS_ALU;
        case (op)
            OP_LUI: begin
                dec.legal = 1'b1;
                dec.a_sel = A_SEL_ZERO;
            end
            OP_AUIPC: begin
                dec.legal = 1'b1;
                dec.a_sel = A_SEL_PC;
            end
            OP_JAL: begin
                dec.legal  = 1'b1;
                dec.a_sel  = A_SEL_PC;
                dec.wb_sel = WB_SEL_PC4;
                dec.pc_sel = PC_SEL_ALU;
                dec.cls    = CLS_JUMP;
            end
            OP_JALR: begin
                dec.legal  = (funct3 == 3'd0);
                dec.wb_sel = WB_SEL_PC4;
                dec.pc_sel = PC_SEL_ALU;
                dec.cls    = CLS_JUMP;
            end
            OP_BTYPE: begin
                dec.legal = (funct3 != 3'd2) && (funct3 != 3'd3);
                dec.b_sel = B_SEL_RS2;
                dec.cls   = CLS_BRANCH;
            end
            OP_LOADS: begin
                dec.legal  = !((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
                dec.wb_sel = WB_SEL_LOAD;
                dec.cls    = CLS_LOAD;
            end
            OP_STORES: begin
                dec.legal = (funct3 < 3'd3);
                dec.cls   = CLS_STORE;
            end
            OP_ARITHM_I: begin
                dec.legal = 1'b1;
            end
            OP_ARITHM_R: begin
                dec.legal = 1'b1;
                dec.b_sel = B_SEL_RS2;
            end
            default: begin
                dec.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - RV32I multi-cycle control FSM with retire counter
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB/TRAP over the shared datapath.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   OPCODE[6:0], FUNCT3[2:0]  decoder fields, latched in DECODE
//   BR_TAKEN                  branch comparator result (used in EXEC)
//   IMEM_READY, DMEM_READY    memory handshakes
//   IMEM_REQ, IR_WE, PC_WE, PC_SEL[1:0], ALU_A_SEL[1:0], ALU_B_SEL,
//   ALUOUT_WE, DMEM_RE, DMEM_WE, WB_SEL[1:0], REG_WE, TRAP  datapath controls
//   INSTRET[INSTRET_W-1:0]    retired-instruction count
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int INSTRET_W   = 32,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [6:0]           OPCODE,
    input  logic [2:0]           FUNCT3,
    input  logic                 BR_TAKEN,
    input  logic                 IMEM_READY,
    input  logic                 DMEM_READY,
    output logic                 IMEM_REQ,
    output logic                 IR_WE,
    output logic                 PC_WE,
    output logic [1:0]           PC_SEL,
    output logic [1:0]           ALU_A_SEL,
    output logic                 ALU_B_SEL,
    output logic                 ALUOUT_WE,
    output logic                 DMEM_RE,
    output logic                 DMEM_WE,
    output logic [1:0]           WB_SEL,
    output logic                 REG_WE,
    output logic                 TRAP,
    output logic [INSTRET_W-1:0] INSTRET
);

    state_t         state, state_nx;
    logic [6:0]     op_q;
    logic [2:0]     f3_q;
    logic [INSTRET_W-1:0] instret_q;
    logic           retire;
    logic [6:0]     dec_op;
    logic [2:0]     dec_f3;
    dec_t           dec;

    // The legality decision is made in DECODE from the live inputs; from
    // EXEC onward only the latched copy is used so input changes are ignored.
    assign dec_op = (state == ST_DECODE) ? OPCODE : op_q;
    assign dec_f3 = (state == ST_DECODE) ? FUNCT3 : f3_q;

    rv_ctrl_decode_table u_decode (
        .op     (dec_op),
        .funct3 (dec_f3),
        .dec    (dec)
    );

    assign INSTRET = instret_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            instret_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE) begin
                op_q <= OPCODE;
                f3_q <= FUNCT3;
            end
            if (retire) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        retire    = 1'b0;
        IMEM_REQ  = 1'b0;
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PC_SEL    = PC_SEL_PLUS4;
        ALU_A_SEL = A_SEL_RS1;
        ALU_B_SEL = B_SEL_RS2;
        ALUOUT_WE = 1'b0;
        DMEM_RE   = 1'b0;
        DMEM_WE   = 1'b0;
        WB_SEL    = WB_SEL_ALU;
        REG_WE    = 1'b0;
        TRAP      = 1'b0;
        case (state)
            ST_FETCH: begin
                IMEM_REQ = 1'b1;
                if (IMEM_READY) begin
                    IR_WE    = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nx = dec.legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                ALUOUT_WE = 1'b1;
                ALU_A_SEL = dec.a_sel;
                ALU_B_SEL = dec.b_sel;
                case (dec.cls)
                    CLS_BRANCH: begin
                        PC_WE    = 1'b1;
                        PC_SEL   = BR_TAKEN ? PC_SEL_BR : PC_SEL_PLUS4;
                        retire   = 1'b1;
                        state_nx = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_nx = ST_MEM;
                    default:             state_nx = ST_WB;
                endcase
            end
            ST_MEM: begin
                DMEM_RE = (dec.cls == CLS_LOAD);
                DMEM_WE = (dec.cls != CLS_LOAD);
                if (DMEM_READY) begin
                    if (dec.cls == CLS_LOAD) begin
                        state_nx = ST_WB;
                    end else begin
                        PC_WE    = 1'b1;
                        retire   = 1'b1;
                        state_nx = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                REG_WE   = 1'b1;
                PC_WE    = 1'b1;
                WB_SEL   = dec.wb_sel;
                PC_SEL   = dec.pc_sel;
                retire   = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_TRAP: begin
                TRAP = 1'b1;
                if (!TRAP_STICKY) begin
                    // Skip the faulting word: PC+4 without retiring it.
                    PC_WE    = 1'b1;
                    state_nx = ST_FETCH;
                end
            end
            default: state_nx = ST_FETCH;
        endcase
        // Reset silences every strobe in the same cycle, whatever the state.
        if (RST) begin
            retire    = 1'b0;
            IMEM_REQ  = 1'b0;
            IR_WE     = 1'b0;
            PC_WE     = 1'b0;
            PC_SEL    = PC_SEL_PLUS4;
            ALU_A_SEL = A_SEL_RS1;
            ALU_B_SEL = B_SEL_RS2;
            ALUOUT_WE = 1'b0;
            DMEM_RE   = 1'b0;
            DMEM_WE   = 1'b0;
            WB_SEL    = WB_SEL_ALU;
            REG_WE    = 1'b0;
            TRAP      = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb/tb_rv_multicycle_ctrl.sv - scoreboard bench for rv_multicycle_ctrl
module tb_rv_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [6:0]  OPCODE = '0;
    logic [2:0]  FUNCT3 = '0;
    logic        BR_TAKEN = 1'b0;
    logic        IMEM_READY = 1'b0;
    logic        DMEM_READY = 1'b0;
    logic        IMEM_REQ, IR_WE, PC_WE, ALU_B_SEL, ALUOUT_WE;
    logic        DMEM_RE, DMEM_WE, REG_WE, TRAP;
    logic [1:0]  PC_SEL, ALU_A_SEL, WB_SEL;
    logic [31:0] INSTRET;

    always #5 CLK = ~CLK;

    rv_multicycle_ctrl #(.INSTRET_W(32), .TRAP_STICKY(1'b1)) dut (
        .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
        .BR_TAKEN(BR_TAKEN), .IMEM_READY(IMEM_READY), .DMEM_READY(DMEM_READY),
        .IMEM_REQ(IMEM_REQ), .IR_WE(IR_WE), .PC_WE(PC_WE), .PC_SEL(PC_SEL),
        .ALU_A_SEL(ALU_A_SEL), .ALU_B_SEL(ALU_B_SEL), .ALUOUT_WE(ALUOUT_WE),
        .DMEM_RE(DMEM_RE), .DMEM_WE(DMEM_WE), .WB_SEL(WB_SEL), .REG_WE(REG_WE),
        .TRAP(TRAP), .INSTRET(INSTRET)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic        ir_we;
        logic        aluout_we;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic        dmem_re;
        logic        dmem_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic        trap;
        logic [31:0] instret;
    } obs_t;

    obs_t        exp_q[$];
    logic [31:0] cyc = '0;
    logic [31:0] exp_instret = '0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge CLK) cyc <= cyc + 32'd1;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic push(input logic ir = 1'b0, input logic alu = 1'b0,
                        input logic [1:0] a = 2'd0, input logic b = 1'b0,
                        input logic re = 1'b0, input logic we = 1'b0,
                        input logic pcwe = 1'b0, input logic [1:0] pcs = 2'd0,
                        input logic rw = 1'b0, input logic [1:0] wb = 2'd0,
                        input logic tr = 1'b0);
        obs_t e;
        e.cyc = cyc; e.ir_we = ir; e.aluout_we = alu; e.a_sel = a; e.b_sel = b;
        e.dmem_re = re; e.dmem_we = we; e.pc_we = pcwe; e.pc_sel = pcs;
        e.reg_we = rw; e.wb_sel = wb; e.trap = tr; e.instret = exp_instret;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with any strobe is matched against the queue head.
    always @(negedge CLK) begin
        obs_t act, e;
        if (IR_WE | ALUOUT_WE | DMEM_RE | DMEM_WE | PC_WE | REG_WE | TRAP) begin
            act = '{cyc, IR_WE, ALUOUT_WE, ALU_A_SEL, ALU_B_SEL, DMEM_RE, DMEM_WE,
                    PC_WE, PC_SEL, REG_WE, WB_SEL, TRAP, INSTRET};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe cyc=%0d actual=%h required=none", cyc, act);
            end else begin
                e = exp_q.pop_front();
                if (!e.aluout_we) begin act.a_sel = '0; act.b_sel = '0; e.a_sel = '0; e.b_sel = '0; end
                if (!e.pc_we)     begin act.pc_sel = '0; e.pc_sel = '0; end
                if (!e.reg_we)    begin act.wb_sel = '0; e.wb_sel = '0; end
                if (act === e) n_pass++;
                else $display("FAIL strobes cyc=%0d actual=%h required=%h", e.cyc, act, e);
            end
        end
    end

    // kind: 0 register writeback, 1 branch, 2 load, 3 store
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int iwait, input int dwait, input int kind,
                             input logic [1:0] a, input logic b,
                             input logic [1:0] wb, input logic [1:0] pcs,
                             input logic br, input logic noise, input logic swap);
        IMEM_READY = 1'b0; DMEM_READY = noise; BR_TAKEN = 1'b0;
        repeat (iwait) step();
        OPCODE = op; FUNCT3 = f3; IMEM_READY = 1'b1;
        push(.ir(1'b1));
        step();                               // DECODE
        IMEM_READY = noise;
        step();                               // EXEC
        BR_TAKEN = br;
        if (noise) OPCODE = 7'b1111111;
        if (kind == 1) begin
            push(.alu(1'b1), .a(a), .b(b), .pcwe(1'b1), .pcs(br ? 2'd2 : 2'd0));
            exp_instret++;
            step();
        end else begin
            push(.alu(1'b1), .a(a), .b(b));
            step();                           // MEM or WB
            DMEM_READY = 1'b0;
            if (kind == 2 || kind == 3) begin
                if (swap) OPCODE = 7'b0110011;
                repeat (dwait) begin
                    push(.re(kind == 2), .we(kind == 3));
                    step();
                end
                DMEM_READY = 1'b1;
                if (kind == 3) begin
                    push(.we(1'b1), .pcwe(1'b1), .pcs(2'd0));
                    exp_instret++;
                end else begin
                    push(.re(1'b1));
                end
                step();
                DMEM_READY = 1'b0;
            end
            if (kind != 3) begin
                push(.rw(1'b1), .pcwe(1'b1), .pcs(pcs), .wb(wb));
                exp_instret++;
                step();
            end
        end
        IMEM_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        IMEM_READY = 1'b1;
        repeat (3) step();
        chk("rst_imem_req", {31'd0, IMEM_REQ}, 32'd0);
        chk("rst_ir_we", {31'd0, IR_WE}, 32'd0);
        chk("rst_instret", INSTRET, 32'd0);
        RST = 1'b0;
        IMEM_READY = 1'b0;
        #1;
        chk("first_fetch_req", {31'd0, IMEM_REQ}, 32'd1);

        // ADDI x1,x0,5 : RS1,IMM, WB_SEL 0, PC_SEL 0
        run_instr(7'b0010011, 3'd0, 0, 0, 0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("instret_after_addi", INSTRET, 32'd1);
        // LW with two data wait cycles
        run_instr(7'b0000011, 3'd2, 0, 2, 2, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        // BEQ taken, then not taken
        run_instr(7'b1100011, 3'd0, 0, 0, 1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'd0, 0, 0, 1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("instret_after_branches", INSTRET, 32'd4);
        // JALR, JAL, LUI, AUIPC
        run_instr(7'b1100111, 3'd0, 0, 0, 0, 2'd0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        run_instr(7'b1101111, 3'd0, 1, 0, 0, 2'd1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        run_instr(7'b0110111, 3'd0, 0, 0, 0, 2'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        run_instr(7'b0010111, 3'd0, 0, 0, 0, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        // ADD with fetch waits and stray READYs outside their states
        run_instr(7'b0110011, 3'd0, 2, 0, 0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        // SW with OPCODE switched to R-type during MEM
        run_instr(7'b0100011, 3'd2, 0, 1, 3, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("instret_after_sw", INSTRET, 32'd10);

        // Reset in the middle of a load's data wait
        OPCODE = 7'b0000011; FUNCT3 = 3'd2; IMEM_READY = 1'b1;
        push(.ir(1'b1));
        step(); IMEM_READY = 1'b0;
        step(); push(.alu(1'b1), .a(2'd0), .b(1'b1));
        step(); push(.re(1'b1));
        step(); RST = 1'b1; #1;
        chk("rst_mid_mem_dmem_re", {31'd0, DMEM_RE}, 32'd0);
        step(); RST = 1'b0; #1;
        exp_instret = '0;
        chk("post_rst_fetch", {31'd0, IMEM_REQ}, 32'd1);
        chk("post_rst_dmem_re", {31'd0, DMEM_RE}, 32'd0);
        chk("post_rst_instret", INSTRET, 32'd0);

        // ADDI, then JALR funct3=1 traps and stays trapped
        run_instr(7'b0010011, 3'd0, 0, 0, 0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        OPCODE = 7'b1100111; FUNCT3 = 3'd1; IMEM_READY = 1'b1;
        push(.ir(1'b1));
        step(); IMEM_READY = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            push(.tr(1'b1));
            step();
        end
        RST = 1'b1;
        step(); RST = 1'b0; #1;
        chk("trap_cleared", {31'd0, TRAP}, 32'd0);
        chk("trap_rst_fetch", {31'd0, IMEM_REQ}, 32'd1);
        chk("trap_rst_instret", INSTRET, 32'd0);

        step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
